// File: rtl/f32_mult_pkg.sv
// rtl/f32_mult_pkg.sv - shared constants, state/class enums and helpers for the binary32 multiplier
package f32_mult_pkg;

    localparam int          BIAS        = 127;
    localparam int          EXP_W       = 8;
    localparam int          MAN_W       = 23;
    localparam int          MULT_CYCLES = 24;
    localparam logic [31:0] QNAN        = 32'h7FC00000;
    localparam logic [31:0] PINF        = 32'h7F800000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND
    } state_t;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    function automatic fp_class_t classify(input logic [30:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = x[EXP_W+MAN_W-1:MAN_W];
        f = x[MAN_W-1:0];
        if (e == '0) return (f == '0) ? FP_ZERO : FP_SUB;
        if (e == '1) return (f == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

    // Leading-zero count; an all-zero input returns 48.
    function automatic logic [5:0] lzc48(input logic [47:0] x);
        logic [5:0] n;
        n = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (x[i]) n = 6'(47 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/f32_round_pack.sv
// rtl/f32_round_pack.sv - RNE rounding and binary32 packing with overflow to infinity
module f32_round_pack
    import f32_mult_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exponent,
    input  logic [47:0]       mant,
    input  logic              sticky,
    output logic [31:0]       result
);

    logic        guard;
    logic        sticky_all;
    logic        inc;
    logic [8:0]  exp_field;
    logic [31:0] sum;

    // Adding the increment to {exponent, fraction} lets a fraction carry bump the
    // exponent, including the subnormal-to-normal transition when bit 47 is clear.
    always_comb begin
        guard      = mant[23];
        sticky_all = sticky | (|mant[22:0]);
        inc        = guard & (sticky_all | mant[24]);
        exp_field  = mant[47] ? exponent[8:0] : 9'd0;
        sum        = {exp_field, mant[46:24]} + {31'd0, inc};
        if ((mant[47] && (exponent >= 10'sd255)) || (sum[31:23] >= 9'd255)) begin
            result = {sign, PINF[30:0]};
        end else begin
            result = {sign, sum[30:0]};
        end
    end

endmodule

// File: rtl/f32_mult.sv
// rtl/f32_mult.sv - binary32 multiplier with start/done handshake, shift-add mantissa, fixed latency
// Build option F32_MULT_SUBNORMAL_EN: gradual underflow; undefined gives DAZ/FTZ.
module f32_mult
    import f32_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic        done,
    output logic [31:0] p
);

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               sign_q;
    logic [23:0]        ma_q;
    logic [23:0]        mb_q;
    logic [4:0]         cnt_q;
    logic [47:0]        prod_q;
    logic signed [9:0]  exp_q;
    logic [47:0]        mant_q;
    logic               sticky_q;
    logic               flush_q;
    logic               spec_q;
    logic [31:0]        spec_val_q;

    fp_class_t          cls_a_raw;
    fp_class_t          cls_b_raw;
    fp_class_t          cls_a;
    fp_class_t          cls_b;
    logic               sign_u;
    logic signed [9:0]  ea_eff;
    logic signed [9:0]  eb_eff;
    logic               spec_u;
    logic [31:0]        spec_val_u;

    logic [5:0]         lz;
    logic [47:0]        norm_mant;
    logic signed [9:0]  exp_adj;
    logic [47:0]        mant_n;
    logic signed [9:0]  exp_n;
    logic               sticky_n;
    logic               flush_n;
    logic [31:0]        rounded;

    assign cls_a_raw = classify(a_q[30:0]);
    assign cls_b_raw = classify(b_q[30:0]);

`ifdef F32_MULT_SUBNORMAL_EN
    assign cls_a = cls_a_raw;
    assign cls_b = cls_b_raw;
`else
    assign cls_a = (cls_a_raw == FP_SUB) ? FP_ZERO : cls_a_raw;
    assign cls_b = (cls_b_raw == FP_SUB) ? FP_ZERO : cls_b_raw;
`endif

    assign sign_u = a_q[31] ^ b_q[31];
    assign ea_eff = (a_q[30:23] == 8'd0) ? 10'sd1 : signed'({2'b00, a_q[30:23]});
    assign eb_eff = (b_q[30:23] == 8'd0) ? 10'sd1 : signed'({2'b00, b_q[30:23]});

    // Special operands: NaN first, then infinity, then zero.
    always_comb begin
        spec_u     = 1'b1;
        spec_val_u = 32'd0;
        if (cls_a == FP_NAN || cls_b == FP_NAN ||
            (cls_a == FP_INF && cls_b == FP_ZERO) ||
            (cls_a == FP_ZERO && cls_b == FP_INF)) begin
            spec_val_u = QNAN;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            spec_val_u = {sign_u, PINF[30:0]};
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            spec_val_u = {sign_u, 31'd0};
        end else begin
            spec_u = 1'b0;
        end
    end

`ifdef F32_MULT_SUBNORMAL_EN
    logic [9:0] rsh;

    always_comb begin
        lz        = lzc48(prod_q);
        norm_mant = prod_q << lz;
        exp_adj   = exp_q + 10'sd1 - signed'({4'd0, lz});
        mant_n    = norm_mant;
        exp_n     = exp_adj;
        sticky_n  = 1'b0;
        flush_n   = 1'b0;
        rsh       = 10'd0;
        if (exp_adj <= 10'sd0) begin
            rsh   = 10'sd1 - exp_adj;
            exp_n = 10'sd0;
            if (rsh >= 10'd48) begin
                mant_n   = 48'd0;
                sticky_n = |norm_mant;
            end else begin
                mant_n   = norm_mant >> rsh[5:0];
                sticky_n = |(norm_mant & ~({48{1'b1}} << rsh[5:0]));
            end
        end
    end
`else
    always_comb begin
        lz        = lzc48(prod_q);
        norm_mant = prod_q << lz;
        exp_adj   = exp_q + 10'sd1 - signed'({4'd0, lz});
        mant_n    = norm_mant;
        exp_n     = exp_adj;
        sticky_n  = 1'b0;
        flush_n   = (exp_adj <= 10'sd0);
    end
`endif

    f32_round_pack u_round_pack (
        .sign     (sign_q),
        .exponent (exp_q),
        .mant     (mant_q),
        .sticky   (sticky_q),
        .result   (rounded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = S_MULT;
            S_MULT:   if (cnt_q == 5'(MULT_CYCLES - 1)) state_nxt = S_NORM;
            S_NORM:   state_nxt = S_ROUND;
            S_ROUND:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            ma_q       <= '0;
            mb_q       <= '0;
            cnt_q      <= '0;
            prod_q     <= '0;
            exp_q      <= '0;
            mant_q     <= '0;
            sticky_q   <= 1'b0;
            flush_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            done       <= 1'b0;
            p          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                S_UNPACK: begin
                    sign_q     <= sign_u;
                    ma_q       <= {|a_q[30:23], a_q[22:0]};
                    mb_q       <= {|b_q[30:23], b_q[22:0]};
                    exp_q      <= ea_eff + eb_eff - signed'(10'(BIAS));
                    spec_q     <= spec_u;
                    spec_val_q <= spec_val_u;
                    prod_q     <= '0;
                    cnt_q      <= '0;
                end
                S_MULT: begin
                    if (mb_q[cnt_q]) prod_q <= prod_q + ({24'd0, ma_q} << cnt_q);
                    cnt_q <= cnt_q + 5'd1;
                end
                S_NORM: begin
                    mant_q   <= mant_n;
                    exp_q    <= exp_n;
                    sticky_q <= sticky_n;
                    flush_q  <= flush_n;
                end
                S_ROUND: begin
                    done <= 1'b1;
                    if (spec_q)       p <= spec_val_q;
                    else if (flush_q) p <= {sign_q, 31'd0};
                    else              p <= rounded;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_f32_mult.sv
// tb/tb_f32_mult.sv - self-checking bench for f32_mult against an exact-arithmetic reference
module tb_f32_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        done;
    logic [31:0] p;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    f32_mult dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .start (start),
        .done  (done),
        .p     (p)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // 0 zero, 1 subnormal, 2 normal, 3 inf, 4 NaN
    function automatic int cls(input logic [31:0] x);
        if (x[30:23] == 8'h00) return (x[22:0] == 23'd0) ? 0 : 1;
        if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 3 : 4;
        return 2;
    endfunction

    function automatic real f2r(input logic [31:0] x);
        int e;
        e = int'(x[30:23]);
        if (e == 0) return real'(x[22:0]) * (2.0 ** (-149));
        return real'({1'b1, x[22:0]}) * (2.0 ** (e - 150));
    endfunction

    // Exact product in double precision, then IEEE RNE conversion to binary32.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          cx, cy;
        real         v;
        logic [63:0] db, dm, kept;
        int          e_unb, sh, fe;
        logic        g, st;
        s  = x[31] ^ y[31];
        cx = cls(x);
        cy = cls(y);
`ifndef F32_MULT_SUBNORMAL_EN
        if (cx == 1) cx = 0;
        if (cy == 1) cy = 0;
`endif
        if (cx == 4 || cy == 4 || (cx == 3 && cy == 0) || (cx == 0 && cy == 3)) return 32'h7FC00000;
        if (cx == 3 || cy == 3) return {s, 8'hFF, 23'd0};
        if (cx == 0 || cy == 0) return {s, 31'd0};
        v = f2r(x) * f2r(y);
`ifndef F32_MULT_SUBNORMAL_EN
        if (v < 2.0 ** (-126)) return {s, 31'd0};
`endif
        db    = $realtobits(v);
        dm    = {11'd0, 1'b1, db[51:0]};
        e_unb = int'(db[62:52]) - 1023;
        sh    = (e_unb >= -126) ? 29 : 29 + (-126 - e_unb);
        if (sh > 60) return {s, 31'd0};
        kept = dm >> sh;
        g    = dm[sh-1];
        st   = (dm & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0;
        if (g && (st || kept[0])) kept = kept + 64'd1;
        if (e_unb >= -126) begin
            fe = e_unb + 127;
            if (kept == (64'd1 << 24)) begin
                kept = kept >> 1;
                fe++;
            end
            if (fe >= 255) return {s, 8'hFF, 23'd0};
            return {s, 8'(fe), kept[22:0]};
        end
        return {s, kept[30:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          r;
        logic [31:0] v;
        r = $urandom_range(0, 15);
        v = $urandom;
        case (r)
            0:       v[30:0] = 31'd0;
            1: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
            end
            2:       v[30:23] = 8'h00;
            3, 4, 5: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check_eq("done_low_after_start", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_done(input logic [31:0] want, input string tag, input bit poke);
        int lat;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (poke && k == 10) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end
            if (poke && k == 11) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'd27);
        check_eq(tag, p, want);
    endtask

    logic [31:0] dx [11];
    logic [31:0] dy [11];
    logic [31:0] dw [11];

    initial begin
        logic [31:0] x, y;
        int          saw;

        dx = '{32'h3F800000, 32'h40400000, 32'hBF800000, 32'h3F800001, 32'h7F800000, 32'hFF800000,
               32'h7F7FFFFF, 32'h00800000, 32'h7FC00001, 32'h80000000, 32'h3F800000};
        dy = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h3F800001, 32'h00000000, 32'h40000000,
               32'h40000000, 32'h3F000000, 32'hBF800000, 32'h40000000, 32'h3F800000};
`ifdef F32_MULT_SUBNORMAL_EN
        dw = '{32'h40000000, 32'h41100000, 32'hBF800000, 32'h3F800002, 32'h7FC00000, 32'hFF800000,
               32'h7F800000, 32'h00400000, 32'h7FC00000, 32'h80000000, 32'h3F800000};
`else
        dw = '{32'h40000000, 32'h41100000, 32'hBF800000, 32'h3F800002, 32'h7FC00000, 32'hFF800000,
               32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h80000000, 32'h3F800000};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset done", {31'd0, done}, 32'd0);
        check_eq("reset p", p, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Odd entries follow a 2-cycle gap; even ones start on the edge done falls.
        for (int i = 0; i < 11; i++) begin
            if (i % 2 == 1) begin
                repeat (2) @(posedge clk);
                #1;
            end
            issue(dx[i], dy[i]);
            wait_done(dw[i], $sformatf("dir%0d %08h*%08h", i, dx[i], dy[i]), 1'b0);
        end

        issue(32'h40400000, 32'h40400000);
        wait_done(32'h41100000, "start ignored mid-op", 1'b1);

        issue(32'h40400000, 32'h3F800000);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid-op reset done", {31'd0, done}, 32'd0);
        check_eq("mid-op reset p", p, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) saw = 1;
        end
        check_eq("no done after reset", 32'(saw), 32'd0);
        issue(32'hC0000000, 32'h40400000);
        wait_done(32'hC0C00000, "after reset", 1'b0);

        for (int i = 0; i < 60; i++) begin
            x = rand_op();
            y = rand_op();
            issue(x, y);
            wait_done(model(x, y), $sformatf("rand %08h*%08h", x, y), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
